uart_reg_bank: RTL and testbench
================================

UART_REG_BANK -- requirements
Module: uart_reg_bank

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, entries per TX and RX FIFO; power of two, 2..128.
REQ-002 SHALL have parameter ADDR_W, default 12, APB address width; only paddr_i[4:0] is decoded, and the upper bits SHALL be zero for a hit.
REQ-003 SHALL have port clk  in  1  clock; all state on rising edge.
REQ-004 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports psel_i, penable_i, pwrite_i  in  1 each  APB control.
REQ-006 SHALL have ports paddr_i  in  ADDR_W; pwdata_i  in  32; pstrb_i  in  4  APB address, write data, byte strobes.
REQ-007 SHALL have ports prdata_o  out  32; pready_o  out  1; pslverr_o  out  1  APB response.
REQ-008 SHALL have ports tx_data_o  out  8; tx_valid_o  out  1; tx_ready_i  in  1  TX byte stream to the transmitter.
REQ-009 SHALL have ports rx_data_i  in  8; rx_valid_i  in  1; parity_error_i  in  1  RX byte stream from the receiver; parity_error_i is a one-cycle pulse.
REQ-010 SHALL have ports data_bit_num_o  out  2; stop_bit_num_o, parity_en_o, parity_type_o  out  1 each  line configuration.
REQ-011 SHALL have port irq_o  out  1  level interrupt.

Function
REQ-012 Access phase = psel_i & penable_i; pready_o SHALL be constant 1 (zero wait states); writes and pops take effect at the clock edge that ends the access phase.
REQ-013 Map: 0x00 TXDATA (W), 0x04 RXDATA (R, pop), 0x08 CFG (RW), 0x0C CTRL (RW), 0x10 STT (R, W1C), 0x14 IER (RW).
REQ-014 CFG[4:0] SHALL drive {parity_type, parity_en, stop_bit_num, data_bit_num[1:0]}; CTRL[0]=TX_EN; CTRL[1]=TX_FLUSH and CTRL[2]=RX_FLUSH are write-1 self-clearing and always read 0.
REQ-015 Writes to CFG, CTRL and IER SHALL update only the bytes whose pstrb_i bit is set; unimplemented bits SHALL read 0.
REQ-016 A TXDATA write with pstrb_i[0]=1 SHALL push pwdata_i[7:0] if the TX FIFO is not full; if full, the byte is dropped and pslverr_o=1; TXDATA reads return 0.
REQ-017 tx_valid_o SHALL equal TX_EN & !tx_empty; tx_data_o SHALL be the FIFO head; a pop occurs on tx_valid_o & tx_ready_i.
REQ-018 rx_valid_i SHALL push rx_data_i when the RX FIFO is not full, or when it is full and popped in the same cycle; otherwise the byte is dropped and STT.OVR is set.
REQ-019 An RXDATA read SHALL return {24'b0, head} and pop; if the FIFO is empty it returns 0, does not pop, and pslverr_o=1.
REQ-020 STT fields: [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty, [4] PERR sticky, [5] OVR sticky, [15:8] tx level, [23:16] rx level.
REQ-021 PERR SHALL be set by parity_error_i; PERR and OVR SHALL be cleared by writing 1 with pstrb_i[0]=1; set SHALL win over a same-cycle clear.
REQ-022 A flush SHALL empty the FIFO at that edge; flush SHALL win over a same-cycle push or pop on the same FIFO.
REQ-023 pslverr_o SHALL be 1 during the access phase for: unmapped address, write to RXDATA, or the conditions in REQ-016 and REQ-019; a faulting access has no side effect.
REQ-024 prdata_o SHALL be 0 outside read access phases.
REQ-025 Simultaneous push and pop on a non-full, non-empty FIFO SHALL keep the level unchanged; pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-026 On reset_n low, asynchronously: FIFOs empty, CFG=CTRL=IER=0, PERR=OVR=0.
REQ-027 Outputs during reset: tx_valid_o=0, tx_data_o=0, config outputs 0, irq_o=0, prdata_o=0, pslverr_o=0, pready_o=1.
REQ-028 Reset asserted mid-transfer SHALL discard FIFO contents without emitting a partial handshake.

Configuration
REQ-029 Macro UART_REG_BANK_IRQ_EN defined: IER[3:0] enables {OVR, PERR, !rx_empty, tx_empty}; irq_o = OR of enabled sources, registered with 1-cycle latency.
REQ-030 Macro undefined: no IER storage; 0x14 reads 0 and writes are ignored without error; irq_o is tied to 0.

Verification
REQ-031 Write 0x41,0x42 to TXDATA with TX_EN=1 and tx_ready_i=1 -> tx_data_o presents 0x41 then 0x42 on consecutive valid cycles; STT[1]=1 afterwards.
REQ-032 Push 9 bytes with TX_EN=0 and DEPTH=8 -> 9th write pslverr_o=1; STT[15:8]=8; STT[0]=1.
REQ-033 Push 9 RX bytes with no reads -> OVR=1; then 8 RXDATA reads return the first 8 bytes in order; 9th read returns 0 with pslverr_o=1.
REQ-034 Write CFG 0x0000_0015 with pstrb=0x1 -> data_bit_num_o=1, parity_en_o=0, stop_bit_num_o=1, parity_type_o=1; a later write with pstrb=0x2 leaves CFG[7:0] unchanged.
REQ-035 parity_error_i pulses in the same cycle as a STT write of 0x10 -> PERR stays 1; the next write of 0x10 clears it.
REQ-036 With IRQ_EN defined, IER=0x2 and one RX byte -> irq_o=1 one cycle after the push; RXDATA read -> irq_o=0 one cycle later.

Source files
------------

// File: rtl/uart_reg_bank_if.sv
// APB slave bus bundle for uart_reg_bank; signal suffixes are from the slave's point of view.
interface uart_reg_bank_if #(parameter int ADDR_W = 12);
    logic              psel_i;
    logic              penable_i;
    logic              pwrite_i;
    logic [ADDR_W-1:0] paddr_i;
    logic [31:0]       pwdata_i;
    logic [3:0]        pstrb_i;
    logic [31:0]       prdata_o;
    logic              pready_o;
    logic              pslverr_o;

    modport master (
        output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i, pstrb_i,
        input  prdata_o, pready_o, pslverr_o
    );
    modport slave (
        input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i, pstrb_i,
        output prdata_o, pready_o, pslverr_o
    );
endinterface

// File: rtl/uart_reg_bank.sv
// UART register bank: APB registers, TX/RX byte FIFOs, sticky status and line configuration.
// Optional interrupt logic is built when UART_REG_BANK_IRQ_EN is defined.
module uart_reg_bank #(
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 12
) (
    input  logic             clk,
    input  logic             reset_n,
    uart_reg_bank_if.slave   apb,
    output logic [7:0]       tx_data_o,
    output logic             tx_valid_o,
    input  logic             tx_ready_i,
    input  logic [7:0]       rx_data_i,
    input  logic             rx_valid_i,
    input  logic             parity_error_i,
    output logic [1:0]       data_bit_num_o,
    output logic             stop_bit_num_o,
    output logic             parity_en_o,
    output logic             parity_type_o,
    output logic             irq_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [2:0] REG_TX = 3'd0, REG_RX = 3'd1, REG_CFG = 3'd2,
                           REG_CTRL = 3'd3, REG_STT = 3'd4, REG_IER = 3'd5;

    // Index 0 is the TX FIFO, index 1 the RX FIFO.
    logic [1:0]         fifo_push, fifo_pop, fifo_flush;
    logic [1:0][7:0]    fifo_din, fifo_head;
    logic [1:0][AW:0]   fifo_cnt;

    logic [4:0] cfg_reg;
    logic       tx_en_reg, perr_reg, ovr_reg;
    logic       access, mapped, err, acc_ok;
    logic [2:0] word_idx;
    logic [31:0] rdata;
    logic       tx_empty, tx_full, rx_empty, rx_full;
    logic       wr_cfg, wr_ctrl, wr_stt, ovr_set;
    logic       unused_bits;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fifo
            logic [7:0]    mem [FIFO_DEPTH];
            logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
            logic [AW:0]   cnt_reg;

            always_ff @(posedge clk) begin
                if (fifo_push[gi] && !fifo_flush[gi])
                    mem[wr_ptr_reg] <= fifo_din[gi];
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    cnt_reg    <= '0;
                end else if (fifo_flush[gi]) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    cnt_reg    <= '0;
                end else begin
                    if (fifo_push[gi]) wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    if (fifo_pop[gi])  rd_ptr_reg <= rd_ptr_reg + 1'b1;
                    cnt_reg <= cnt_reg + {{AW{1'b0}}, fifo_push[gi]} - {{AW{1'b0}}, fifo_pop[gi]};
                end
            end

            assign fifo_head[gi] = mem[rd_ptr_reg];
            assign fifo_cnt[gi]  = cnt_reg;
        end
    endgenerate

    assign tx_empty = (fifo_cnt[0] == '0);
    assign tx_full  = (fifo_cnt[0] == FULL_CNT);
    assign rx_empty = (fifo_cnt[1] == '0);
    assign rx_full  = (fifo_cnt[1] == FULL_CNT);

    // Address decode: only word-aligned offsets 0x00..0x14 with zero upper bits hit.
    assign access   = apb.psel_i & apb.penable_i;
    assign word_idx = apb.paddr_i[4:2];
    assign mapped   = (apb.paddr_i[ADDR_W-1:5] == '0) && (apb.paddr_i[1:0] == 2'b00)
                      && (word_idx <= REG_IER);

    always_comb begin
        err = 1'b0;
        if (!mapped) begin
            err = 1'b1;
        end else begin
            case (word_idx)
                REG_TX:  err = apb.pwrite_i & apb.pstrb_i[0] & tx_full;
                REG_RX:  err = apb.pwrite_i | rx_empty;
                default: err = 1'b0;
            endcase
        end
    end

    assign acc_ok  = access & ~err;
    assign wr_cfg  = acc_ok & apb.pwrite_i & (word_idx == REG_CFG)  & apb.pstrb_i[0];
    assign wr_ctrl = acc_ok & apb.pwrite_i & (word_idx == REG_CTRL) & apb.pstrb_i[0];
    assign wr_stt  = acc_ok & apb.pwrite_i & (word_idx == REG_STT)  & apb.pstrb_i[0];

    assign fifo_din[0]   = apb.pwdata_i[7:0];
    assign fifo_push[0]  = acc_ok & apb.pwrite_i & (word_idx == REG_TX) & apb.pstrb_i[0];
    assign fifo_pop[0]   = tx_valid_o & tx_ready_i;
    assign fifo_flush[0] = wr_ctrl & apb.pwdata_i[1];

    // A full RX FIFO still accepts a byte when a read pops in the same cycle.
    assign fifo_din[1]   = rx_data_i;
    assign fifo_pop[1]   = acc_ok & ~apb.pwrite_i & (word_idx == REG_RX);
    assign fifo_push[1]  = rx_valid_i & (~rx_full | fifo_pop[1]);
    assign fifo_flush[1] = wr_ctrl & apb.pwdata_i[2];
    assign ovr_set       = rx_valid_i & rx_full & ~fifo_pop[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg_reg   <= '0;
            tx_en_reg <= 1'b0;
            perr_reg  <= 1'b0;
            ovr_reg   <= 1'b0;
        end else begin
            if (wr_cfg)  cfg_reg   <= apb.pwdata_i[4:0];
            if (wr_ctrl) tx_en_reg <= apb.pwdata_i[0];
            perr_reg <= parity_error_i | (perr_reg & ~(wr_stt & apb.pwdata_i[4]));
            ovr_reg  <= ovr_set        | (ovr_reg  & ~(wr_stt & apb.pwdata_i[5]));
        end
    end

`ifdef UART_REG_BANK_IRQ_EN
    logic [3:0] ier_reg;
    logic       irq_reg;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ier_reg <= '0;
            irq_reg <= 1'b0;
        end else begin
            if (acc_ok && apb.pwrite_i && (word_idx == REG_IER) && apb.pstrb_i[0])
                ier_reg <= apb.pwdata_i[3:0];
            irq_reg <= |(ier_reg & {ovr_reg, perr_reg, ~rx_empty, tx_empty});
        end
    end
    assign irq_o = irq_reg;
`else
    assign irq_o = 1'b0;
`endif

    always_comb begin
        rdata = 32'h0;
        case (word_idx)
            REG_RX:   rdata = {24'h0, fifo_head[1]};
            REG_CFG:  rdata = {27'h0, cfg_reg};
            REG_CTRL: rdata = {31'h0, tx_en_reg};
            REG_STT:  rdata = {8'h0, 8'(fifo_cnt[1]), 8'(fifo_cnt[0]), 2'b00, ovr_reg, perr_reg,
                               rx_empty, rx_full, tx_empty, tx_full};
`ifdef UART_REG_BANK_IRQ_EN
            REG_IER:  rdata = {28'h0, ier_reg};
`endif
            default:  rdata = 32'h0;
        endcase
    end

    // Response is also forced quiet while reset is held.
    assign apb.prdata_o  = (reset_n && acc_ok && !apb.pwrite_i) ? rdata : 32'h0;
    assign apb.pslverr_o = reset_n & access & err;
    assign apb.pready_o  = 1'b1;

    assign tx_valid_o     = tx_en_reg & ~tx_empty;
    assign tx_data_o      = tx_empty ? 8'h00 : fifo_head[0];
    assign data_bit_num_o = cfg_reg[1:0];
    assign stop_bit_num_o = cfg_reg[2];
    assign parity_en_o    = cfg_reg[3];
    assign parity_type_o  = cfg_reg[4];

    assign unused_bits = ^{apb.pwdata_i[31:8], apb.pstrb_i[3:1]};
endmodule

// File: tb/tb_uart_reg_bank.sv
// Scoreboard bench for uart_reg_bank: stimulus queues expected APB/TX responses, a monitor checks them.
module tb_uart_reg_bank;
    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] tx_data_o;
    logic       tx_valid_o, tx_ready_i;
    logic [7:0] rx_data_i;
    logic       rx_valid_i, parity_error_i;
    logic [1:0] data_bit_num_o;
    logic       stop_bit_num_o, parity_en_o, parity_type_o, irq_o;

    int check_cnt = 0;
    int pass_cnt  = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
        string       name;
    } apb_exp_t;
    apb_exp_t   apb_q[$];
    logic [7:0] tx_q[$];

    uart_reg_bank_if #(.ADDR_W(12)) bus ();

    uart_reg_bank #(.FIFO_DEPTH(8), .ADDR_W(12)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .apb            (bus.slave),
        .tx_data_o      (tx_data_o),
        .tx_valid_o     (tx_valid_o),
        .tx_ready_i     (tx_ready_i),
        .rx_data_i      (rx_data_i),
        .rx_valid_i     (rx_valid_i),
        .parity_error_i (parity_error_i),
        .data_bit_num_o (data_bit_num_o),
        .stop_bit_num_o (stop_bit_num_o),
        .parity_en_o    (parity_en_o),
        .parity_type_o  (parity_type_o),
        .irq_o          (irq_o)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endfunction

    // Monitor: every APB access phase and every TX handshake consumes one expectation.
    always @(negedge clk) begin
        if (bus.psel_i && bus.penable_i) begin
            if (apb_q.size() == 0) begin
                check("apb_unexpected_access", 32'd1, 32'd0);
            end else begin
                apb_apply(apb_q.pop_front());
            end
        end else begin
            check("prdata_idle", bus.prdata_o, 32'h0);
        end
        if (tx_valid_o && tx_ready_i) begin
            if (tx_q.size() == 0) begin
                check("tx_unexpected_byte", {24'h0, tx_data_o}, 32'hFFFF_FFFF);
            end else begin
                logic [7:0] eb;
                eb = tx_q.pop_front();
                $display("tx byte 0x%02h (expected 0x%02h)", tx_data_o, eb);
                check("tx_data", {24'h0, tx_data_o}, {24'h0, eb});
            end
        end
    end

    function automatic void apb_apply(input apb_exp_t e);
        $display("apb %s addr=0x%03h %s prdata=0x%08h pslverr=%0b", e.name, bus.paddr_i,
                 bus.pwrite_i ? "W" : "R", bus.prdata_o, bus.pslverr_o);
        check(e.name, bus.prdata_o, e.data);
        check({e.name, "_err"}, {31'h0, bus.pslverr_o}, {31'h0, e.err});
        check({e.name, "_ready"}, {31'h0, bus.pready_o}, 32'h1);
    endfunction

    task automatic apb_xfer(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, input logic [31:0] exp_data,
                            input logic exp_err, input string name,
                            input logic perr_pulse = 1'b0,
                            input logic rx_inj = 1'b0, input logic [7:0] rx_byte = 8'h00);
        @(posedge clk); #1;
        bus.psel_i = 1'b1; bus.penable_i = 1'b0; bus.pwrite_i = wr;
        bus.paddr_i = addr; bus.pwdata_i = wdata; bus.pstrb_i = strb;
        @(posedge clk); #1;
        bus.penable_i  = 1'b1;
        parity_error_i = perr_pulse;
        rx_valid_i     = rx_inj;
        rx_data_i      = rx_byte;
        apb_q.push_back('{exp_data, exp_err, name});
        @(posedge clk); #1;
        bus.psel_i = 1'b0; bus.penable_i = 1'b0; bus.pwrite_i = 1'b0;
        parity_error_i = 1'b0; rx_valid_i = 1'b0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic e, input string n);
        apb_xfer(1'b1, a, d, s, 32'h0, e, n);
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] x, input logic e, input string n);
        apb_xfer(1'b0, a, 32'h0, 4'h0, x, e, n);
    endtask

    initial begin
        reset_n = 1'b0;
        bus.psel_i = 1'b0; bus.penable_i = 1'b0; bus.pwrite_i = 1'b0;
        bus.paddr_i = '0; bus.pwdata_i = '0; bus.pstrb_i = '0;
        tx_ready_i = 1'b0; rx_data_i = 8'h0; rx_valid_i = 1'b0; parity_error_i = 1'b0;

        // Outputs while reset is held
        repeat (2) @(posedge clk);
        #1;
        check("rst_tx_valid", {31'h0, tx_valid_o}, 32'h0);
        check("rst_tx_data", {24'h0, tx_data_o}, 32'h0);
        check("rst_cfg_out", {27'h0, parity_type_o, parity_en_o, stop_bit_num_o, data_bit_num_o}, 32'h0);
        check("rst_irq", {31'h0, irq_o}, 32'h0);
        check("rst_pready", {31'h0, bus.pready_o}, 32'h1);
        check("rst_pslverr", {31'h0, bus.pslverr_o}, 32'h0);
        @(negedge clk) reset_n = 1'b1;

        rd(12'h010, 32'h0000_000A, 1'b0, "stt_after_reset");
        rd(12'h008, 32'h0, 1'b0, "cfg_after_reset");

        // Line configuration with byte strobes
        wr(12'h008, 32'h0000_0015, 4'h1, 1'b0, "cfg_wr");
        check("data_bit_num", {30'h0, data_bit_num_o}, 32'h1);
        check("stop_bit_num", {31'h0, stop_bit_num_o}, 32'h1);
        check("parity_en", {31'h0, parity_en_o}, 32'h0);
        check("parity_type", {31'h0, parity_type_o}, 32'h1);
        wr(12'h008, 32'h0000_00FF, 4'h2, 1'b0, "cfg_wr_strb2");
        rd(12'h008, 32'h0000_0015, 1'b0, "cfg_rd_unchanged");
        wr(12'h00C, 32'h0000_0001, 4'h2, 1'b0, "ctrl_wr_strb2");
        rd(12'h00C, 32'h0, 1'b0, "ctrl_rd_unchanged");

        // TX FIFO fill with TX_EN=0: 9th write overflows
        for (int i = 0; i < 9; i++)
            wr(12'h000, 32'h10 + i, 4'h1, (i == 8), "tx_fill");
        rd(12'h010, 32'h0000_0809, 1'b0, "stt_tx_full");
        wr(12'h00C, 32'h0000_0002, 4'h1, 1'b0, "ctrl_tx_flush");
        rd(12'h00C, 32'h0, 1'b0, "ctrl_flush_reads0");
        rd(12'h010, 32'h0000_000A, 1'b0, "stt_after_flush");

        // TX stream: two bytes on consecutive handshakes
        wr(12'h00C, 32'h0000_0001, 4'h1, 1'b0, "ctrl_tx_en");
        wr(12'h000, 32'h41, 4'h1, 1'b0, "tx_wr_41"); tx_q.push_back(8'h41);
        wr(12'h000, 32'h42, 4'h1, 1'b0, "tx_wr_42"); tx_q.push_back(8'h42);
        check("tx_valid_held", {31'h0, tx_valid_o}, 32'h1);
        check("tx_head", {24'h0, tx_data_o}, 32'h41);
        @(posedge clk); #1 tx_ready_i = 1'b1;
        repeat (4) @(posedge clk);
        #1 tx_ready_i = 1'b0;
        rd(12'h010, 32'h0000_000A, 1'b0, "stt_tx_drained");

        // RX overflow: 9 bytes, no reads
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1 rx_valid_i = 1'b1; rx_data_i = 8'h60 + 8'(i);
        end
        @(posedge clk); #1 rx_valid_i = 1'b0;
        rd(12'h010, 32'h0008_0026, 1'b0, "stt_rx_full_ovr");
        for (int i = 0; i < 8; i++)
            rd(12'h004, 32'h60 + i, 1'b0, "rx_rd");
        rd(12'h004, 32'h0, 1'b1, "rx_rd_empty");
        rd(12'h010, 32'h0000_002A, 1'b0, "stt_ovr_sticky");
        wr(12'h010, 32'h0000_0020, 4'h1, 1'b0, "stt_clr_ovr");
        rd(12'h010, 32'h0000_000A, 1'b0, "stt_ovr_cleared");

        // Push and pop in the same cycle keep the level
        @(posedge clk); #1 rx_valid_i = 1'b1; rx_data_i = 8'h70;
        @(posedge clk); #1 rx_valid_i = 1'b0;
        apb_xfer(1'b0, 12'h004, 32'h0, 4'h0, 32'h70, 1'b0, "rx_rd_with_push", 1'b0, 1'b1, 8'h71);
        rd(12'h010, 32'h0001_0002, 1'b0, "stt_level_kept");
        rd(12'h004, 32'h71, 1'b0, "rx_rd_71");

        // Parity error set wins over a same-cycle clear
        @(posedge clk); #1 parity_error_i = 1'b1;
        @(posedge clk); #1 parity_error_i = 1'b0;
        rd(12'h010, 32'h0000_001A, 1'b0, "stt_perr_set");
        apb_xfer(1'b1, 12'h010, 32'h10, 4'h1, 32'h0, 1'b0, "stt_clr_vs_set", 1'b1);
        rd(12'h010, 32'h0000_001A, 1'b0, "stt_perr_kept");
        wr(12'h010, 32'h10, 4'h1, 1'b0, "stt_clr_perr");
        rd(12'h010, 32'h0000_000A, 1'b0, "stt_perr_cleared");

        // Address decode faults
        rd(12'h018, 32'h0, 1'b1, "rd_unmapped");
        rd(12'h104, 32'h0, 1'b1, "rd_upper_bits");
        rd(12'h00A, 32'h0, 1'b1, "rd_unaligned");
        wr(12'h004, 32'h55, 4'h1, 1'b1, "wr_rxdata");
        rd(12'h000, 32'h0, 1'b0, "rd_txdata");
        rd(12'h010, 32'h0000_000A, 1'b0, "stt_no_side_effect");

        // Interrupt enable register and irq latency
`ifdef UART_REG_BANK_IRQ_EN
        wr(12'h014, 32'h2, 4'h1, 1'b0, "ier_wr");
        rd(12'h014, 32'h2, 1'b0, "ier_rd");
`else
        wr(12'h014, 32'hF, 4'h1, 1'b0, "ier_wr_ignored");
        rd(12'h014, 32'h0, 1'b0, "ier_rd_zero");
`endif
        @(posedge clk); #1 rx_valid_i = 1'b1; rx_data_i = 8'h77;
        @(posedge clk); #1 rx_valid_i = 1'b0;
        check("irq_push_edge", {31'h0, irq_o}, 32'h0);
        @(posedge clk); #1;
`ifdef UART_REG_BANK_IRQ_EN
        check("irq_after_push", {31'h0, irq_o}, 32'h1);
`else
        check("irq_tied_low", {31'h0, irq_o}, 32'h0);
`endif
        rd(12'h004, 32'h77, 1'b0, "rx_rd_77");
        @(posedge clk); #1;
        check("irq_after_pop", {31'h0, irq_o}, 32'h0);

        // Reset in the middle of a pending TX byte
        wr(12'h000, 32'h55, 4'h1, 1'b0, "tx_wr_pending");
        check("tx_pending_valid", {31'h0, tx_valid_o}, 32'h1);
        @(posedge clk); #1 reset_n = 1'b0;
        #1;
        check("midrst_tx_valid", {31'h0, tx_valid_o}, 32'h0);
        check("midrst_tx_data", {24'h0, tx_data_o}, 32'h0);
        tx_ready_i = 1'b1;
        @(negedge clk) reset_n = 1'b1;
        rd(12'h010, 32'h0000_000A, 1'b0, "stt_after_midrst");
        rd(12'h00C, 32'h0, 1'b0, "ctrl_after_midrst");
        rd(12'h008, 32'h0, 1'b0, "cfg_after_midrst");

        repeat (4) @(posedge clk);
        #1;
        check("tx_q_drained", tx_q.size(), 32'd0);
        check("apb_q_drained", apb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
